// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and bit-period helper.
// UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;
  localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_e;
`endif
  function automatic int clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (8E1 with UART_RX_PARITY_EN) UART receiver, mid-bit sampling,
// framing and optional even-parity error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK  = 50_000_000,
  parameter int BAUD = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       idle_o
);
  localparam int CPB = clks_per_bit(CLK, BAUD);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_e AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_e AFTER_DATA = STOP;
`endif
  generate
    if (CPB < 16) begin : g_cpb_check
      $error("uart_rx: CLK/BAUD must be at least 16");
    end
  endgenerate
  logic                 rx_s;
  uart_rx_state_e       state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 expire;
  assign expire = cnt == '0;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk_i), .rst_n(rst_n_i), .d(rx_i), .q(rx_s));
`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err_o = 1'b0;
`endif
  // cnt free-runs outside a frame; IDLE reloads it with the half-bit offset
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      idle_o      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      cnt <= expire ? FULL : cnt - 1'b1;
      case (state)
        IDLE:
          if (!rx_s) begin
            state   <= START;
            bit_cnt <= '0;
            cnt     <= HALF;
            idle_o  <= 1'b0;
          end
        START:
          if (expire) begin
            state  <= rx_s ? IDLE : DATA;
            idle_o <= rx_s;
          end
        DATA:
          if (expire) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= bit_cnt == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (expire) begin
            par_bad <= ^shift ^ rx_s;
            state   <= STOP;
          end
`endif
        STOP:
          if (expire) begin
            if (rx_s) begin
              rx_data_o <= shift;
`ifdef UART_RX_PARITY_EN
              rx_valid_o   <= !par_bad;
              parity_err_o <= par_bad;
`else
              rx_valid_o <= 1'b1;
`endif
              state  <= IDLE;
              idle_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        BREAK:
          if (rx_s) begin
            state  <= IDLE;
            idle_o <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level model.
module tb_uart_rx;
  localparam int CLK = 3_200_000;
  localparam int BAUD = 100_000;
  localparam int CPB = CLK / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = CPB / 2 + (9 + P) * CPB;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, perr, idle;
  int errors = 0, checks = 0;
  int cyc = 0;
  int fcnt = 0, pcnt = 0, multi = 0;
  logic [7:0] vdata[$];
  int vcyc[$];
  int start_cyc = 0;
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.CLK(CLK), .BAUD(BAUD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx), .rx_data_o(data),
    .rx_valid_o(valid), .frame_err_o(ferr), .parity_err_o(perr), .idle_o(idle));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      vdata.push_back(data);
      vcyc.push_back(cyc);
    end
    if (ferr) fcnt <= fcnt + 1;
    if (perr) pcnt <= pcnt + 1;
    if (int'(valid) + int'(ferr) + int'(perr) > 1) multi <= multi + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // one whole frame on the line; par_ok selects correct or inverted even parity
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_ok);
    rx = 1'b0;
    start_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ !par_ok);
`endif
    drive_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", perr); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    rst_n = 1'b1;
    tick(4);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle got=%b exp=1", idle); end
  endtask

  task automatic test_loopback();
    int n0 = vdata.size(), f0 = fcnt, p0 = pcnt;
    send(8'hAA, 1'b1, 1'b1);
    exp_data = 8'hAA;
    checks++; if (vdata.size() - n0 !== 1) begin errors++; $display("FAIL lb_valid_count got=%0d exp=1", vdata.size() - n0); end
    if (vdata.size() > n0) begin
      checks++; if (vdata[n0] !== 8'hAA) begin errors++; $display("FAIL lb_data got=%h exp=aa", vdata[n0]); end
      checks++;
      if (vcyc[n0] - start_cyc < LAT + 2 || vcyc[n0] - start_cyc > LAT + 4) begin
        errors++; $display("FAIL lb_latency got=%0d exp=%0d..%0d", vcyc[n0] - start_cyc, LAT + 2, LAT + 4);
      end
    end
    checks++; if (fcnt - f0 + pcnt - p0 !== 0) begin errors++; $display("FAIL lb_err_pulses got=%0d exp=0", fcnt - f0 + pcnt - p0); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL lb_idle_at_stop_end got=%b exp=1", idle); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic stop_b, pok;
    int n0, f0, p0, exp_v, exp_f, exp_p;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      stop_b = $urandom_range(0, 4) != 0;
`ifdef UART_RX_PARITY_EN
      pok = $urandom_range(0, 3) != 0;
`else
      pok = 1'b1;
`endif
      n0 = vdata.size(); f0 = fcnt; p0 = pcnt;
      send(d, stop_b, pok);
      exp_v = (stop_b && pok) ? 1 : 0;
      exp_f = stop_b ? 0 : 1;
      exp_p = (stop_b && !pok) ? 1 : 0;
      if (stop_b) exp_data = d;
      checks++; if (vdata.size() - n0 !== exp_v) begin errors++; $display("FAIL rnd%0d_valid got=%0d exp=%0d", k, vdata.size() - n0, exp_v); end
      checks++; if (fcnt - f0 !== exp_f) begin errors++; $display("FAIL rnd%0d_ferr got=%0d exp=%0d", k, fcnt - f0, exp_f); end
      checks++; if (pcnt - p0 !== exp_p) begin errors++; $display("FAIL rnd%0d_perr got=%0d exp=%0d", k, pcnt - p0, exp_p); end
      checks++; if (data !== exp_data) begin errors++; $display("FAIL rnd%0d_data got=%h exp=%h", k, data, exp_data); end
      if (vdata.size() > n0) begin
        checks++; if (vdata[n0] !== d) begin errors++; $display("FAIL rnd%0d_pulse_data got=%h exp=%h", k, vdata[n0], d); end
      end
      tick(stop_b ? $urandom_range(0, 3) : 4);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = vdata.size();
    send(8'h55, 1'b1, 1'b1);
    send(8'hC3, 1'b1, 1'b1);
    exp_data = 8'hC3;
    checks++; if (vdata.size() - n0 !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", vdata.size() - n0); end
    if (vdata.size() >= n0 + 2) begin
      checks++; if (vdata[n0] !== 8'h55) begin errors++; $display("FAIL b2b_first got=%h exp=55", vdata[n0]); end
      checks++; if (vdata[n0 + 1] !== 8'hC3) begin errors++; $display("FAIL b2b_second got=%h exp=c3", vdata[n0 + 1]); end
      checks++;
      if (vcyc[n0 + 1] - vcyc[n0] !== (10 + P) * CPB) begin
        errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", vcyc[n0 + 1] - vcyc[n0], (10 + P) * CPB);
      end
    end
    tick(3);
  endtask

  task automatic test_glitch();
    int n0 = vdata.size(), f0 = fcnt, p0 = pcnt;
    rx = 1'b0;
    tick(6);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL glitch_start_seen got=%b exp=0", idle); end
    tick(4);
    rx = 1'b1;
    tick(CPB);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL glitch_idle got=%b exp=1", idle); end
    checks++; if (vdata.size() - n0 + fcnt - f0 + pcnt - p0 !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", vdata.size() - n0 + fcnt - f0 + pcnt - p0); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_data got=%h exp=%h", data, exp_data); end
  endtask

  task automatic test_frame_err();
    int n0 = vdata.size(), f0 = fcnt, p0 = pcnt;
    send(8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    checks++; if (fcnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", fcnt - f0); end
    checks++; if (vdata.size() - n0 !== 0) begin errors++; $display("FAIL ferr_valid got=%0d exp=0", vdata.size() - n0); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL ferr_data got=%h exp=%h", data, exp_data); end
    tick(20 * CPB);
    checks++; if (vdata.size() - n0 + fcnt - f0 - 1 + pcnt - p0 !== 0) begin errors++; $display("FAIL break_pulses got=%0d exp=0", vdata.size() - n0 + fcnt - f0 - 1 + pcnt - p0); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL break_idle got=%b exp=0", idle); end
    rx = 1'b1;
    tick(4);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL break_exit_idle got=%b exp=1", idle); end
    n0 = vdata.size();
    send(8'h81, 1'b1, 1'b1);
    exp_data = 8'h81;
    checks++; if (vdata.size() - n0 !== 1) begin errors++; $display("FAIL after_break_valid got=%0d exp=1", vdata.size() - n0); end
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL after_break_data got=%h exp=81", data); end
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hF0;
    int n0 = vdata.size(), f0 = fcnt, p0 = pcnt;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    tick(CPB / 2);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", idle); end
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got=%h exp=00", data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", idle); end
    checks++; if ({valid, ferr, perr} !== 3'b000) begin errors++; $display("FAIL mid_rst_pulses got=%b exp=000", {valid, ferr, perr}); end
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    exp_data = 8'h00;
    tick(3);
    send(8'h0F, 1'b1, 1'b1);
    exp_data = 8'h0F;
    checks++; if (vdata.size() - n0 !== 1) begin errors++; $display("FAIL mid_next_valid got=%0d exp=1", vdata.size() - n0); end
    checks++; if (data !== 8'h0F) begin errors++; $display("FAIL mid_next_data got=%h exp=0f", data); end
    checks++; if (fcnt - f0 + pcnt - p0 !== 0) begin errors++; $display("FAIL mid_partial_pulses got=%0d exp=0", fcnt - f0 + pcnt - p0); end
    tick(2);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n0 = vdata.size(), p0 = pcnt;
    send(8'h07, 1'b1, 1'b0);
    checks++; if (pcnt - p0 !== 1) begin errors++; $display("FAIL par_bad_pulse got=%0d exp=1", pcnt - p0); end
    checks++; if (vdata.size() - n0 !== 0) begin errors++; $display("FAIL par_bad_valid got=%0d exp=0", vdata.size() - n0); end
    checks++; if (data !== 8'h07) begin errors++; $display("FAIL par_bad_data got=%h exp=07", data); end
    send(8'h07, 1'b1, 1'b1);
    exp_data = 8'h07;
    checks++; if (vdata.size() - n0 !== 1) begin errors++; $display("FAIL par_ok_valid got=%0d exp=1", vdata.size() - n0); end
    checks++; if (pcnt - p0 !== 1) begin errors++; $display("FAIL par_ok_perr got=%0d exp=1", pcnt - p0); end
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_random();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    tick(2);
    checks++; if (multi !== 0) begin errors++; $display("FAIL exclusive_pulses got=%0d exp=0", multi); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the downstream partner of `uart_tx`: deserialises an 8N1 asynchronous serial line into bytes in the same clock domain. Samples each bit at its nominal centre, flags framing errors and optionally checks even parity. Sits between the pad-level `rx` line and the byte consumer, and in loopback benches it takes `tx_o` of `uart_tx` directly.

## Interface
- `CLK`, 50000000, system clock frequency in Hz
- `BAUD`, 115200, line bit rate; `CPB = CLK/BAUD` (integer division, 434 at defaults); elaboration `$error` if `CPB < 16`
- `clk_i`  in  1  system clock, all logic on rising edge
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `rx_i`  in  1  serial line, idle high, asynchronous to `clk_i`
- `rx_data_o`  out  8  last received byte, held until next completed frame
- `rx_valid_o`  out  1  one-cycle pulse: `rx_data_o` updated with a good frame
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch (tied 0 without `UART_RX_PARITY_EN`)
- `idle_o`  out  1  high while the FSM is in IDLE

## Operation
- `rx_i` passes through a 2-FF synchroniser reset to 1; all logic uses the synchronised level `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- IDLE: `rx_s == 0` → START, bit counter cleared, baud counter loaded with `CPB/2 - 1`.
- START: at counter expiry resample; `rx_s == 1` → IDLE (glitch, no output). `rx_s == 0` → DATA, counter reload `CPB - 1`.
- DATA: at each expiry shift `rx_s` into the MSB of an 8-bit shift register (LSB-first on the line). After 8 samples → PARITY or STOP.
- PARITY: one sample; compare with the XOR of the 8 data bits (even parity: the XOR of data and parity bit must be 0).
- STOP: one sample. If `rx_s == 1`, load `rx_data_o`. Then pulse `rx_valid_o` if parity is OK, else pulse `parity_err_o` (`rx_data_o` still loaded). Return to IDLE.
- STOP with `rx_s == 0`: pulse `frame_err_o`, leave `rx_data_o` unchanged, go to BREAK. BREAK: wait for `rx_s == 1`, then IDLE.
- `rx_valid_o`, `frame_err_o` and `parity_err_o` are mutually exclusive.
- No backpressure: the consumer must take `rx_data_o` before the next frame completes. An unread byte is overwritten silently.

## Timing
- Reset values: `rx_data_o = 8'h00`, `rx_valid_o = 0`, `frame_err_o = 0`, `parity_err_o = 0`, `idle_o = 1`, FSM = IDLE, shift register = 0.
- Let t0 be the first cycle `rx_s == 0` in IDLE, which is 2–3 cycles after the `rx_i` edge.
  - Start sample: t0 + CPB/2.
  - Data bit n (0..7): t0 + CPB/2 + (n+1)·CPB.
  - Parity bit: t0 + CPB/2 + 9·CPB.
  - Stop bit: t0 + CPB/2 + (9+P)·CPB, with P = 1 when parity is compiled in.
- Status pulses and the `rx_data_o` update are registered and appear on the cycle after the stop sample.
- `idle_o` rises on that same cycle, so back-to-back frames are accepted with no gap: re-arm is at mid-stop bit.
- Reset mid-frame: all state returns to reset values immediately, and no pulse is emitted for the partial frame.
- Line held low at reset release: treated as a start. This gives `frame_err_o`, then BREAK until the line goes high.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, frames are 8E1, and `parity_err_o` is live.
- Not defined: 8N1 only, the PARITY state is absent, and `parity_err_o` is constant 0. The port stays present so the interface is identical in both builds.

## Structure
- Package `uart_pkg`: the `uart_rx_state_e` enum, the `DATA_BITS = 8` constant, and the function `clks_per_bit(CLK, BAUD)`, shared with `uart_tx`.
- Sub-module `sync_2ff`: a generic 2-flop synchroniser with a reset-value parameter, instantiated with reset value 1.
- Baud counter, bit counter, shift register and FSM stay inline in `uart_rx`.

## Test plan
- Loopback from `uart_tx` at defaults, sending 0xAA: one `rx_valid_o` pulse with `rx_data_o = 8'hAA`, no error pulses, and `idle_o` high again before the `uart_tx` `idle_o` rises.
- Back-to-back 0x55 then 0xC3 with zero idle gap: two valid pulses about 10·CPB cycles apart, carrying 0x55 then 0xC3.
- 100 ns low glitch on an idle line: return to IDLE after the start sample, no pulses, `rx_data_o` unchanged.
- Frame 0x3C with the stop bit forced low: `frame_err_o` pulse, no `rx_valid_o`, `rx_data_o` keeps its previous value. Line held low 20·CPB: no further pulses until high, after which 0x81 is received correctly.
- `rst_n_i` low at bit 4 of a 0xF0 frame: outputs go to reset values immediately, and a following 0x0F frame is received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong): `parity_err_o` pulse, `rx_data_o = 8'h07`. Send 0x07 with parity bit 1: `rx_valid_o` pulse.
